clock_div_ctrl: RTL and testbench
=================================

CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 25: width of the counter, limit and configuration datapath.
REQ-002 SHALL have parameter DEF_LIMIT, default 25'd32000000: divide ratio after reset, sized for the Papilio 32 MHz clock giving 1 Hz.
REQ-003 SHALL have parameter MIN_LIMIT, default 2: smallest accepted divide ratio.
REQ-004 SHALL have port clk_in, input, 1 bit: the only clock; all state updates on the posedge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port run, input, 1 bit: level request to generate clk_out.
REQ-007 SHALL have port cfg_valid, input, 1 bit: a new divide ratio is offered.
REQ-008 SHALL have port cfg_limit, input, WIDTH bits: the offered divide ratio, in clk_in cycles per clk_out period.
REQ-009 SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration this cycle.
REQ-010 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an accepted ratio is rejected.
REQ-011 SHALL have port clk_out, output, 1 bit: the divided clock (a registered level).
REQ-012 SHALL have port tick, output, 1 bit: one-cycle pulse on the last cycle of each clk_out period.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 SHALL hold active_limit, shadow_limit and counter registers, each WIDTH bits.
REQ-015 SHALL implement the states IDLE, RUN and PEND.
REQ-016 SHALL, in RUN/PEND, count counter 0..active_limit-1; at active_limit-1 it wraps to 0 on the next edge.
REQ-017 SHALL drive clk_out high exactly on the cycles where counter >= (active_limit>>1) in RUN/PEND, and low in IDLE; duty is floor-half low, rest high.
REQ-018 SHALL assert tick for exactly one cycle when counter == active_limit-1 in RUN/PEND, and never in IDLE.
REQ-019 SHALL drive cfg_ready = 1 in IDLE and RUN, and 0 in PEND.
REQ-020 SHALL accept a transfer only when cfg_valid && cfg_ready on a clock edge.
REQ-021 SHALL, for a transfer with cfg_limit < MIN_LIMIT, pulse cfg_err the next cycle and leave registers and state unchanged.
REQ-022 SHALL, for a valid transfer in IDLE, load active_limit directly on that edge.
REQ-023 SHALL, for a valid transfer in RUN, load shadow_limit and go to PEND; the current period completes on the old ratio.
REQ-024 SHALL, in PEND at counter == active_limit-1, set active_limit <= shadow_limit and counter <= 0, and go to RUN (or IDLE if run = 0).
REQ-025 SHALL, in IDLE with run = 1, go to RUN with counter = 0; the first clk_out low phase starts the next cycle.
REQ-026 SHALL, when run falls in RUN/PEND, finish the current period and enter IDLE at the wrap; no truncated clk_out pulse.
REQ-027 SHALL give a rate change priority when a wrap, a run drop and a transfer coincide: the PEND load happens first, then IDLE; a transfer in RUN on the wrap cycle enters PEND.
REQ-028 SHALL make an accepted ratio take effect at the start of the next period: latency is at most old active_limit cycles.

Reset
REQ-029 SHALL, while reset is high, asynchronously force: state IDLE, counter 0, active_limit and shadow_limit DEF_LIMIT, clk_out 0, tick 0, cfg_err 0, busy 0, cfg_ready 1.
REQ-030 SHALL, on reset mid-period or mid-PEND, discard the pending ratio.
REQ-031 SHALL resume normal operation on the first posedge after reset deasserts.

Verification (WIDTH=8, DEF_LIMIT=8 unless stated)
REQ-032 SHALL check: reset, then run=1 for 24 cycles -> clk_out 0000_1111 repeated 3 times; tick on cycles 8, 16, 24; busy=1.
REQ-033 SHALL check: in RUN at counter=2, send cfg_limit=4 -> cfg_ready drops; the rest of the period stays 8; then the pattern is 0011 with tick every 4; cfg_ready returns 1.
REQ-034 SHALL check: send cfg_limit=1, then cfg_limit=0 -> cfg_err pulses once each; period stays 8; state unchanged.
REQ-035 SHALL check: drop run at counter=3 -> clk_out completes 1111 and tick fires; then IDLE, clk_out 0, busy 0.
REQ-036 SHALL check: assert reset while in PEND (shadow=4) -> all outputs at reset values immediately; after release with run=1 the period is 8.
REQ-037 SHALL check: cfg_limit=5 in IDLE, then run -> clk_out 00111 repeated; tick every 5.

Source files
------------

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: programmable clock divider with a ready/valid ratio interface.
//
// Ports
//   clk_in     : the only clock; all state changes on its rising edge
//   reset      : asynchronous, active-high reset
//   run        : level request to generate clk_out
//   cfg_valid  : a new divide ratio is offered on cfg_limit
//   cfg_limit  : offered ratio, in clk_in cycles per clk_out period
//   cfg_ready  : a configuration can be accepted this cycle (low while a change is pending)
//   cfg_err    : one-cycle pulse after an accepted ratio below MIN_LIMIT is rejected
//   clk_out    : divided clock, registered; low for floor(limit/2) cycles, then high
//   tick       : one-cycle pulse on the last cycle of each clk_out period
//   busy       : high whenever the divider is not idle
//
// A ratio offered while running is held in a shadow register and applied at
// the end of the current period, so clk_out never shows a truncated phase.
module clock_div_ctrl #(
  parameter int unsigned       WIDTH     = 25,
  parameter logic [WIDTH-1:0]  DEF_LIMIT = 25'd32000000,
  parameter int unsigned       MIN_LIMIT = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_limit,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] active_limit_q, active_limit_d;
  logic [WIDTH-1:0] shadow_limit_q, shadow_limit_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_fire;
  logic             cfg_ok;
  logic             wrap;

  assign cfg_ready = (state_q != PEND);
  assign busy      = (state_q != IDLE);
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    active_limit_d = active_limit_q;
    shadow_limit_d = shadow_limit_q;
    cfg_err_d      = 1'b0;

    cfg_fire = cfg_valid && cfg_ready;
    cfg_ok   = (cfg_limit >= MIN_W);
    wrap     = (counter_q == active_limit_q - ONE);

    if (cfg_fire && !cfg_ok) begin
      cfg_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        counter_d = '0;
        if (cfg_fire && cfg_ok) begin
          active_limit_d = cfg_limit;
        end
        if (run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        counter_d = wrap ? '0 : counter_q + ONE;
        // A good transfer always parks in PEND, even on the wrap cycle; the
        // run-drop check is then made at the end of the PEND period instead.
        if (cfg_fire && cfg_ok) begin
          shadow_limit_d = cfg_limit;
          state_d        = PEND;
        end else if (wrap && !run) begin
          state_d = IDLE;
        end
      end
      PEND: begin
        counter_d = counter_q + ONE;
        if (wrap) begin
          active_limit_d = shadow_limit_q;
          counter_d      = '0;
          state_d        = run ? RUN : IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase

    // Outputs are registered from next-state values so that clk_out/tick
    // line up with the counter value held during the same cycle.
    clk_out_d = (state_d != IDLE) && (counter_d >= (active_limit_d >> 1));
    tick_d    = (state_d != IDLE) && (counter_d == active_limit_d - ONE);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      active_limit_q <= DEF_LIMIT;
      shadow_limit_q <= DEF_LIMIT;
      clk_out_q      <= 1'b0;
      tick_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      active_limit_q <= active_limit_d;
      shadow_limit_q <= shadow_limit_d;
      clk_out_q      <= clk_out_d;
      tick_q         <= tick_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Scoreboard bench for clock_div_ctrl (WIDTH=8, DEF_LIMIT=8, MIN_LIMIT=2).
// Stimulus pushes the expected {clk_out,tick,busy,cfg_ready,cfg_err} for the
// cycle after each edge; a monitor pops and compares on the falling edge.
module tb_clock_div_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_limit = '0;
  logic       cfg_ready, cfg_err, clk_out, tick, busy;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] exp;
  } exp_t;

  exp_t sb[$];

  clock_div_ctrl #(
    .WIDTH     (8),
    .DEF_LIMIT (8'd8),
    .MIN_LIMIT (2)
  ) dut (
    .clk_in    (clk),
    .reset     (reset),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_limit (cfg_limit),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every cycle is an output cycle for this block.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
        exp_t e;
        logic [4:0] act;
        e   = sb.pop_front();
        act = {clk_out, tick, busy, cfg_ready, cfg_err};
        total++;
        if (e.cyc < cyc_cnt) begin
          bad++;
          $display("FAIL %s: entry for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc_cnt);
        end else if (act !== e.exp) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%b want=%b {clk_out,tick,busy,rdy,err}", e.name, cyc_cnt, act, e.exp);
        end
      end
    end
  end

  task automatic check_now(input string name, input logic [4:0] want);
    logic [4:0] act;
    act = {clk_out, tick, busy, cfg_ready, cfg_err};
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b {clk_out,tick,busy,rdy,err}", name, act, want);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input string name, input logic r, input logic cv, input int lim,
                     input logic e_clk, input logic e_tick, input logic e_busy,
                     input logic e_rdy, input logic e_err);
    exp_t e;
    run       = r;
    cfg_valid = cv;
    cfg_limit = 8'(lim);
    e.cyc  = cyc_cnt + 1;
    e.name = name;
    e.exp  = {e_clk, e_tick, e_busy, e_rdy, e_err};
    sb.push_back(e);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // Counter positions k0..k1 of a period of length L with no transfer.
  task automatic run_seg(input string name, input int L, input int k0, input int k1,
                         input logic r, input logic rdy);
    for (int k = k0; k <= k1; k++) begin
      cyc(name, r, 1'b0, 0, (k >= L / 2), (k == L - 1), 1'b1, rdy, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check_now("reset_hold", 5'b00010);
    reset = 1'b0;

    // Default ratio 8: 0000_1111 three times, tick every 8th cycle
    for (int p = 0; p < 3; p++) run_seg("div8", 8, 0, 7, 1'b1, 1'b1);

    // Rejected ratios 1 and 0: err pulses, period stays 8
    cyc("err_lim1", 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("err_gap",  1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("err_lim0", 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_seg("err_tail", 8, 3, 7, 1'b1, 1'b1);
    run_seg("err_keep8", 8, 0, 7, 1'b1, 1'b1);

    // Ratio 4 offered at counter 2: old period completes in PEND
    run_seg("pre_cfg4", 8, 0, 2, 1'b1, 1'b1);
    cyc("cfg4_accept", 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_seg("pend_old8", 8, 4, 7, 1'b1, 1'b0);
    run_seg("div4", 4, 0, 3, 1'b1, 1'b1);
    run_seg("div4", 4, 0, 3, 1'b1, 1'b1);

    // Ratio 8 offered on the wrap cycle: one more period of 4 in PEND
    cyc("wrap_cfg8", 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_seg("wrap_pend4", 4, 1, 3, 1'b1, 1'b0);
    run_seg("back_div8", 8, 0, 7, 1'b1, 1'b1);

    // Run dropped at counter 3: period finishes, then idle
    run_seg("drop_pre", 8, 0, 3, 1'b1, 1'b1);
    run_seg("drop_finish", 8, 4, 7, 1'b0, 1'b1);
    cyc("drop_idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("drop_idle2", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset while PEND with shadow 4 and clk_out high
    run_seg("rst_pre", 8, 0, 1, 1'b1, 1'b1);
    cyc("rst_cfg4", 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_seg("rst_pend", 8, 3, 5, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_now("rst_async", 5'b00010);
    @(posedge clk);
    #1;
    check_now("rst_held", 5'b00010);
    reset = 1'b0;
    run_seg("post_rst8", 8, 0, 7, 1'b1, 1'b1);
    run_seg("post_rst8b", 8, 0, 1, 1'b1, 1'b1);
    run_seg("post_rst_drop", 8, 2, 7, 1'b0, 1'b1);
    cyc("post_rst_idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Ratio 5 loaded in IDLE, then run: 00111 with tick every 5
    cyc("idle_cfg5", 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_seg("div5", 5, 0, 4, 1'b1, 1'b1);
    run_seg("div5", 5, 0, 4, 1'b1, 1'b1);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
